// File: rtl/digit_formatter.sv
// Binary-to-digit formatter: sequential double-dabble for decimal, nibble pass-through for hex,
// with a leading-zero blank mask and an overflow flag for the downstream 7-segment decoders.
module digit_formatter #(
    parameter int unsigned WIDTH   = 20,
    parameter int unsigned NDIGITS = 6,
    parameter int unsigned LZB     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   hex_mode,
    input  logic [WIDTH-1:0]       value,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   digits,
    output logic [NDIGITS-1:0]     blank,
    output logic                   overflow
);

    localparam int unsigned DW = 4 * NDIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [NDIGITS-1:0] BLANK_RST = (LZB != 0) ? ~NDIGITS'(1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [DW-1:0]    bcd;
    logic             ovf;
    logic             hex_q;

    logic [DW-1:0]      bcd_adj_c;
    logic [DW-1:0]      hex_digits_c;
    logic               hex_ovf_c;
    logic               res_ovf_c;
    logic [DW-1:0]      res_digits_c;
    logic [NDIGITS-1:0] res_blank_c;

    // Add 3 to every BCD nibble that is 5 or more before the next shift (4-bit, no inter-nibble carry)
    always_comb begin
        bcd_adj_c = bcd;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign hex_digits_c = DW'(shreg);

    // Hex overflow only exists when the value is wider than the digit field
    generate
        if (WIDTH > DW) begin : g_trunc
            assign hex_ovf_c = |shreg[WIDTH-1:DW];
        end else begin : g_fit
            assign hex_ovf_c = 1'b0;
        end
    endgenerate

    // Final result selection, overflow forcing and leading-zero mask
    always_comb begin
        logic zeros_above;
        res_ovf_c = hex_q ? hex_ovf_c : ovf;
        if (res_ovf_c) begin
            res_digits_c = hex_q ? {DW{1'b1}} : {NDIGITS{4'h9}};
        end else begin
            res_digits_c = hex_q ? hex_digits_c : bcd;
        end
        res_blank_c = '0;
        zeros_above = 1'b1;
        for (int k = int'(NDIGITS) - 1; k >= 1; k--) begin
            zeros_above    = zeros_above & (res_digits_c[4*k +: 4] == 4'd0);
            res_blank_c[k] = zeros_above;
        end
        if ((LZB == 0) || res_ovf_c) begin
            res_blank_c = '0;
        end
    end

    // Conversion FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            bcd      <= '0;
            ovf      <= 1'b0;
            hex_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            digits   <= '0;
            blank    <= BLANK_RST;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        shreg <= value;
                        hex_q <= hex_mode;
                        bcd   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= hex_mode ? FINISH : SHIFT;
                    end
                end
                SHIFT: begin
                    bcd   <= {bcd_adj_c[DW-2:0], shreg[WIDTH-1]};
                    shreg <= shreg << 1;
                    ovf   <= ovf | bcd_adj_c[DW-1];
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    digits   <= res_digits_c;
                    blank    <= res_blank_c;
                    overflow <= res_ovf_c;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_formatter.sv
// Scoreboard bench for digit_formatter: driver pushes model results, monitor checks on done.
module tb_digit_formatter;

    localparam int W = 20;
    localparam int N = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           hex_mode;
    logic [W-1:0]   value;
    logic           busy;
    logic           done;
    logic [4*N-1:0] digits;
    logic [N-1:0]   blank;
    logic           overflow;

    digit_formatter #(.WIDTH(W), .NDIGITS(N), .LZB(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hex_mode (hex_mode),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .blank    (blank),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*N-1:0] d;
        logic [N-1:0]   b;
        logic           o;
        bit             hx;
        int             acc;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [4*N-1:0] held_d;
    logic [N-1:0]   held_b;
    logic           held_o;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by repeated division, hex by nibble split
    function automatic exp_t model(input bit hx, input logic [W-1:0] v);
        exp_t e;
        int unsigned x;
        x = v;
        e.hx = hx;
        e.acc = 0;
        e.o = 1'b0;
        e.d = '0;
        if (hx) begin
            e.d = 24'(x);
        end else if (x > 999999) begin
            e.o = 1'b1;
            e.d = 24'h999999;
        end else begin
            for (int k = 0; k < N; k++) begin
                e.d[4*k +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        e.b = '0;
        if (!e.o) begin
            for (int k = 1; k < N; k++) e.b[k] = ((e.d >> (4*k)) == 0);
        end
        return e;
    endfunction

    task automatic set_held_reset();
        held_d = '0;
        held_b = 6'b111110;
        held_o = 1'b0;
    endtask

    // Monitor: compare on done, and verify outputs hold while a conversion is running
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    m_e = sbq.pop_front();
                    chk("latency", 32'(cyc - m_e.acc - 1), m_e.hx ? 32'd1 : 32'd21);
                    chk("digits", 32'(digits), 32'(m_e.d));
                    chk("blank", 32'(blank), 32'(m_e.b));
                    chk("overflow", 32'(overflow), 32'(m_e.o));
                    chk("busy_in_done", 32'(busy), 32'd0);
                    held_d = m_e.d;
                    held_b = m_e.b;
                    held_o = m_e.o;
                end
            end else if (busy) begin
                chk("hold_digits", 32'(digits), 32'(held_d));
                chk("hold_blank", 32'(blank), 32'(held_b));
                chk("hold_overflow", 32'(overflow), 32'(held_o));
            end
        end
    end

    // Drive one start request; caller is positioned just after a falling edge
    task automatic issue(input bit hx, input logic [W-1:0] v);
        exp_t e;
        bit acc;
        acc = !busy;
        start = 1'b1;
        hex_mode = hx;
        value = v;
        if (acc) begin
            e = model(hx, v);
            e.acc = cyc;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        hex_mode = 1'($urandom);
        value = W'($urandom);
        if (acc) chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (sbq.size() != 0 || busy); i++) @(negedge clk);
        @(negedge clk);
        chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_digits"}, 32'(digits), 32'h000000);
        chk({tag, "_blank"}, 32'(blank), 32'b111110);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hex_mode = 1'b0;
        value = '0;
        set_held_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(1'b0, W'(12345));       wait_idle();
        issue(1'b0, 20'hFFFFF);       wait_idle();
        issue(1'b1, 20'hABCDE);       wait_idle();

        // Start while busy is ignored; start in the done cycle is accepted
        issue(1'b0, W'(7));
        repeat (4) @(negedge clk);
        issue(1'b0, W'(999999));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        issue(1'b0, W'(999999));
        wait_idle();

        // Reset mid-conversion aborts without done
        issue(1'b0, W'(500));
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        set_held_reset();
        @(posedge clk);
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        issue(1'b0, W'(500));         wait_idle();

        // Boundaries
        issue(1'b0, W'(999999));      wait_idle();
        issue(1'b0, W'(1000000));     wait_idle();
        issue(1'b0, W'(0));           wait_idle();
        issue(1'b1, W'(0));           wait_idle();
        issue(1'b0, W'(10));          wait_idle();
        issue(1'b1, 20'hFFFFF);       wait_idle();

        // Randomized traffic with interleaved (possibly ignored) starts
        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] v;
            int sel;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      v = W'($urandom_range(0, 99));
            else if (sel == 1) v = W'($urandom_range(0, 999999));
            else               v = W'($urandom);
            @(negedge clk);
            issue(1'($urandom), v);
            if ($urandom_range(0, 2) == 0) begin
                repeat (int'($urandom_range(0, 22)) + 1) @(negedge clk);
                issue(1'($urandom), W'($urandom));
            end
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
